prog_clk_div: RTL and testbench
===============================

# prog_clk_div

Runtime-programmable clock divider: generates a 50 % duty square wave and a one-cycle tick from the 100 MHz system clock, with half-period set by a loadable divisor. It is the parametrised successor to our fixed 2 Hz divider and is the common timebase source for display scan, debounce and game-speed logic. Divisor changes take effect only at a half-period boundary, so `clk_out` never glitches or produces a short phase. The block also supports freeze and synchronous restart.

## Interface
- `WIDTH`, 25: counter and divisor width in bits.
- `DEFAULT_DIV`, 25000000: divisor after reset, in half-period clock cycles. This gives 2 Hz at 100 MHz. Must be in 1 … 2^WIDTH−1.

Ports:
- `clk`  in  1: system clock, single clock domain.
- `rst`  in  1: reset, active-low, synchronous (sampled on posedge `clk` only).
- `en`  in  1: count enable; 0 freezes the divider.
- `clr`  in  1: synchronous restart of phase.
- `div_load`  in  1: single-cycle strobe that captures `div_in`.
- `div_in`  in  WIDTH: requested half-period, in cycles.
- `clk_out`  out  1: divided square wave, registered.
- `tick`  out  1: one-cycle pulse on each `clk_out` toggle, registered.
- `div_cur`  out  WIDTH: divisor currently in effect.
- `pend`  out  1: a loaded divisor is waiting for the next boundary.

## Operation
- Internal state:
  - `cnt` (WIDTH), counting 1 … `div_cur`.
  - `div_cur`.
  - `div_pend` (WIDTH).
  - `pend`.
  - `clk_out`.
  - `tick`.
- Priority per posedge: `rst`=0 > `clr` > normal count. `div_load` capture is evaluated in parallel with `clr` and normal count, as defined below.
- Reset (`rst`=0): `cnt`=1, `div_cur`=`DEFAULT_DIV`, `div_pend`=0, `pend`=0, `clk_out`=0, `tick`=0.
- Divisor clamp: `div_in`=0 is treated as 1 everywhere. No other range checks apply.
- Load with no boundary or clear in the same cycle: `div_pend`←clamp(`div_in`), `pend`←1. A second load before the boundary overwrites `div_pend`; the last load wins.
- Terminal count: a cycle with `en`=1, `clr`=0 and `cnt`==`div_cur`. On it:
  - `cnt`←1.
  - `clk_out`←~`clk_out`.
  - `tick`←1.
  - If `div_load`=1 in the same cycle: `div_cur`←clamp(`div_in`), `pend`←0.
  - Else if `pend`=1: `div_cur`←`div_pend`, `pend`←0.
- Normal cycle (`en`=1, `clr`=0, `cnt`≠`div_cur`): `cnt`←`cnt`+1, `tick`←0.
- Freeze (`en`=0, `clr`=0): `cnt` and `clk_out` hold, `tick`←0. Loads are still captured into `div_pend`/`pend`.
- Clear (`clr`=1): `cnt`←1, `clk_out`←0, `tick`←0.
  - Any divisor is applied immediately: `div_load` this cycle takes precedence over an existing pending value.
  - After clear, `pend`←0.
  - `clr` acts regardless of `en`.
- Invariant: `cnt` ≤ `div_cur` at all times, because `div_cur` changes only when `cnt` is set to 1. No wrap-around of `cnt` is possible.

## Timing
- With `en` held at 1 and D=`div_cur`:
  - `clk_out` toggles every D cycles, giving a period of 2·D cycles.
  - `tick` pulses once every D cycles.
  - `tick` is high in exactly the cycle in which the new `clk_out` value is first visible.
- From reset release (first posedge with `rst`=1, `en`=1): the first toggle is visible after D posedges.
- D=1: `clk_out` toggles every cycle (`clk`/2) and `tick` stays high continuously.
- Load latency: the new divisor governs the half-period that starts at the next boundary. `div_cur` and `pend` update at that same edge, so they are visible one cycle after the boundary edge. The current half-period always completes with the old divisor.
- Freeze is exact: a pause of k cycles stretches the current half-period by exactly k cycles. No tick is emitted while `en`=0.
- All outputs are registered. No combinational path runs from inputs to outputs.

## Test plan
- Reset/free-run, `DEFAULT_DIV`=4:
  - Release `rst` with `en`=1 → `clk_out` rises after 4 cycles and then toggles every 4.
  - `tick` is high 1 cycle in every 4.
  - `div_cur`=4.
- Mid-period load:
  - At `cnt`=2, pulse `div_load` with `div_in`=3 → `pend`=1 and the current half-period still lasts 4 cycles.
  - Subsequent half-periods last 3 cycles.
  - `pend` returns to 0 at the boundary.
- Load coincident with the boundary, plus clamp:
  - Pulse `div_load`, `div_in`=6, on the terminal-count cycle → the next half-period is 6 cycles and `pend` stays 0.
  - Load `div_in`=0 → `div_cur` becomes 1 and `clk_out` toggles every cycle.
- Freeze: drop `en` for 5 cycles at `cnt`=2 (D=4) → `clk_out` and `tick` hold, and that half-period lasts 9 cycles.
- Clear:
  - Assert `clr` with `clk_out`=1 and a pending divisor 5 → the next cycle shows `clk_out`=0, `div_cur`=5, `pend`=0.
  - The first toggle comes 5 cycles after `clr` deasserts.
- Reset mid-operation: assert `rst`=0 for 1 cycle while `clk_out`=1 and `pend`=1 → all outputs return to their reset values at that edge, and `clk_out` is not affected between clock edges.

Source files
------------

// File: rtl/prog_clk_div.sv
// Runtime-programmable clock divider: 50 % duty square wave plus a one-cycle tick per toggle.
// New divisors are applied only at a half-period boundary or on clear, so clk_out never glitches.
module prog_clk_div #(
   parameter int unsigned WIDTH       = 25,
   parameter int unsigned DEFAULT_DIV = 25000000
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_en,
   input  logic             i_clr,
   input  logic             i_div_load,
   input  logic [WIDTH-1:0] i_div_in,
   output logic             o_clk_out,
   output logic             o_tick,
   output logic [WIDTH-1:0] o_div_cur,
   output logic             o_pend
);

   logic [WIDTH-1:0] r_cnt;
   logic [WIDTH-1:0] r_div_cur;
   logic [WIDTH-1:0] r_div_pend;
   logic             r_pend;
   logic             r_clk_out;
   logic             r_tick;

   logic [WIDTH-1:0] w_div_clamped;
   logic             w_terminal;

   // A zero divisor would stall the counter; treat it as one.
   assign w_div_clamped = (i_div_in == '0) ? WIDTH'(1) : i_div_in;
   assign w_terminal    = i_en && (r_cnt == r_div_cur);

   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         r_cnt      <= WIDTH'(1);
         r_div_cur  <= WIDTH'(DEFAULT_DIV);
         r_div_pend <= '0;
         r_pend     <= 1'b0;
         r_clk_out  <= 1'b0;
         r_tick     <= 1'b0;
      end else if (i_clr) begin
         r_cnt     <= WIDTH'(1);
         r_clk_out <= 1'b0;
         r_tick    <= 1'b0;
         r_pend    <= 1'b0;
         if (i_div_load) begin
            r_div_cur <= w_div_clamped;
         end else if (r_pend) begin
            r_div_cur <= r_div_pend;
         end
      end else if (w_terminal) begin
         r_cnt     <= WIDTH'(1);
         r_clk_out <= ~r_clk_out;
         r_tick    <= 1'b1;
         r_pend    <= 1'b0;
         if (i_div_load) begin
            r_div_cur <= w_div_clamped;
         end else if (r_pend) begin
            r_div_cur <= r_div_pend;
         end
      end else begin
         // Normal count or freeze: loads only queue up until the next boundary.
         r_tick <= 1'b0;
         if (i_en) begin
            r_cnt <= r_cnt + WIDTH'(1);
         end
         if (i_div_load) begin
            r_div_pend <= w_div_clamped;
            r_pend     <= 1'b1;
         end
      end
   end

   assign o_clk_out = r_clk_out;
   assign o_tick    = r_tick;
   assign o_div_cur = r_div_cur;
   assign o_pend    = r_pend;

endmodule

// File: tb/tb_prog_clk_div.sv
// Self-checking bench for prog_clk_div: cycle scoreboard of all outputs plus directed
// half-period measurements for load, clamp, freeze, clear and mid-run reset.
module tb_prog_clk_div;

   localparam int unsigned W = 8;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         en = 1'b0;
   logic         clr = 1'b0;
   logic         div_load = 1'b0;
   logic [W-1:0] div_in = '0;
   logic         clk_out;
   logic         tick;
   logic [W-1:0] div_cur;
   logic         pend;

   prog_clk_div #(
      .WIDTH       (W),
      .DEFAULT_DIV (4)
   ) dut (
      .i_clk      (clk),
      .i_rst      (rst),
      .i_en       (en),
      .i_clr      (clr),
      .i_div_load (div_load),
      .i_div_in   (div_in),
      .o_clk_out  (clk_out),
      .o_tick     (tick),
      .o_div_cur  (div_cur),
      .o_pend     (pend)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference state
   int   m_cnt  = 1;
   int   m_div  = 4;
   int   m_pdiv = 0;
   logic m_pend = 1'b0;
   logic m_clk  = 1'b0;
   logic m_tick = 1'b0;

   logic [W+2:0] exp_q[$];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model(input logic r, input logic e, input logic c, input logic ld,
                        input logic [W-1:0] din);
      int   cl;
      int   nd;
      logic tc;
      cl = (din == 0) ? 1 : int'(din);
      if (!r) begin
         m_cnt = 1; m_div = 4; m_pdiv = 0; m_pend = 0; m_clk = 0; m_tick = 0;
      end else begin
         tc = e && !c && (m_cnt == m_div);
         if (c || tc) begin
            nd     = ld ? cl : (m_pend ? m_pdiv : m_div);
            m_div  = nd;
            m_pend = 0;
            m_cnt  = 1;
            m_clk  = c ? 1'b0 : ~m_clk;
            m_tick = tc;
         end else begin
            if (ld) begin
               m_pdiv = cl;
               m_pend = 1;
            end
            if (e) m_cnt++;
            m_tick = 0;
         end
      end
   endtask

   // Drive one cycle, push the expected outputs, then compare after the edge.
   task automatic step(input logic r, input logic e, input logic c, input logic ld,
                       input logic [W-1:0] din);
      logic [W+2:0] exp_v;
      rst = r; en = e; clr = c; div_load = ld; div_in = din;
      model(r, e, c, ld, din);
      exp_q.push_back({m_clk, m_tick, W'(m_div), m_pend});
      @(posedge clk);
      #1;
      exp_v = exp_q.pop_front();
      check("cycle", {clk_out, tick, div_cur, pend}, exp_v);
   endtask

   // Count cycles (from 'start') until the next tick; bounded so a dead DUT cannot hang us.
   task automatic run_to_tick(input string tag, input int start, input int exp);
      int n;
      int guard;
      n = start;
      guard = 0;
      do begin
         step(1, 1, 0, 0, 0);
         n++;
         guard++;
      end while (!tick && guard < 64);
      check(tag, n, exp);
   endtask

   task automatic sync_high(input string tag);
      int guard;
      guard = 0;
      do begin
         step(1, 1, 0, 0, 0);
         guard++;
      end while (!(tick && clk_out) && guard < 64);
      check(tag, clk_out, 1);
   endtask

   initial begin
      // Reset
      repeat (2) step(0, 0, 0, 0, 0);
      check("rst_clk", clk_out, 0);
      check("rst_tick", tick, 0);
      check("rst_div", div_cur, 4);
      check("rst_pend", pend, 0);

      // Free run, D=4
      run_to_tick("first_half", 0, 4);
      check("first_rise", clk_out, 1);
      run_to_tick("half_4a", 0, 4);
      check("fall", clk_out, 0);
      run_to_tick("half_4b", 0, 4);

      // Mid-period load of 3 at cnt=2
      step(1, 1, 0, 0, 0);
      step(1, 1, 0, 1, 3);
      check("mid_pend", pend, 1);
      check("mid_div_old", div_cur, 4);
      run_to_tick("mid_old_half", 2, 4);
      check("mid_pend_clr", pend, 0);
      check("mid_div_new", div_cur, 3);
      run_to_tick("half_3a", 0, 3);
      run_to_tick("half_3b", 0, 3);

      // Load on the terminal-count cycle
      step(1, 1, 0, 0, 0);
      step(1, 1, 0, 0, 0);
      step(1, 1, 0, 1, 6);
      check("tc_tick", tick, 1);
      check("tc_pend", pend, 0);
      check("tc_div", div_cur, 6);
      run_to_tick("half_6", 0, 6);

      // Clamp: 0 -> 1
      step(1, 1, 0, 1, 0);
      run_to_tick("half_6_before_clamp", 1, 6);
      check("clamp_div", div_cur, 1);
      run_to_tick("half_1a", 0, 1);
      run_to_tick("half_1b", 0, 1);

      // Back to D=4 via load on a terminal cycle, then freeze 5 cycles at cnt=2
      step(1, 1, 0, 1, 4);
      check("div4_tick", tick, 1);
      check("div4", div_cur, 4);
      step(1, 1, 0, 0, 0);
      for (int i = 0; i < 5; i++) begin
         step(1, 0, 0, 0, 0);
         check("freeze_tick", tick, 0);
      end
      run_to_tick("freeze_half", 6, 9);

      // Clear with clk_out=1 and divisor 5 pending
      sync_high("clr_setup");
      step(1, 1, 0, 1, 5);
      check("clr_pre_pend", pend, 1);
      step(1, 1, 1, 0, 0);
      check("clr_clk", clk_out, 0);
      check("clr_div", div_cur, 5);
      check("clr_pend", pend, 0);
      run_to_tick("clr_half", 0, 5);

      // Reset mid-operation with clk_out=1, pend=1
      step(1, 1, 0, 1, 7);
      check("rst_mid_setup_clk", clk_out, 1);
      check("rst_mid_setup_pend", pend, 1);
      rst = 1'b0;
      #2;
      check("rst_between_edges", clk_out, 1);
      step(0, 1, 0, 0, 0);
      check("rst_mid_clk", clk_out, 0);
      check("rst_mid_div", div_cur, 4);
      check("rst_mid_pend", pend, 0);
      run_to_tick("after_rst_half", 0, 4);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
